seg7_scanner: RTL
=================

Name: seg7_scanner

Overview:
- Time-multiplexed driver for the 4-digit common-anode 7-segment display on the board.
- Consumes the 16-bit register value selected out of the CPU and produces the active-low anode and cathode buses.
- Sits directly downstream of the CPU register-select path, clocked from the raw sysclk, independent of the CPU's divided or stepped clock.
- Snapshots the value once per frame to prevent tearing and supports leading-zero blanking and per-digit decimal points.

Parameters:
- REFRESH_DIV, 100000, sysclk cycles each digit slot lasts; must be at least 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.
- LZ_BLANK, 1, 1 enables leading-zero suppression.

Ports:
- sysclk  input  1  system clock; the only clock in the block.
- rst  input  1  asynchronous, active-low reset.
- value  input  16  hex value to display; nibble i is shown on digit i, digit 0 is least significant.
- dp_mask  input  4  bit i=1 lights the decimal point of digit i.
- an  output  4  anode enables, active-low; an[i] drives digit i.
- cat  output  8  cathodes, active-low; bits [6:0] are {g,f,e,d,c,b,a}, bit 7 is dp.

Behaviour:
- Reset (rst low, asynchronous): cnt=0, idx=0, snap=0, init=1, an=4'hF, cat=8'hFF. Nothing lights during reset.
- Slot counter, on each sysclk edge:
  - If cnt==REFRESH_DIV-1: cnt<=0 and idx<=idx+1 mod 4 (3 wraps to 0).
  - Otherwise: cnt<=cnt+1.
  - Counter width is clog2(REFRESH_DIV).
- Snapshot:
  - snap<=value when (cnt==REFRESH_DIV-1 and idx==3), i.e. at each new frame.
  - Also snap<=value on the first edge after reset release (init=1, then init<=0). This edge takes priority and is otherwise identical.
  - Changes to value mid-frame never reach the outputs until the next frame.
- Outputs are registered and reflect the (cnt, idx, snap, dp_mask) state of the previous cycle, a fixed 1-cycle latency:
  - If cnt<BLANK_CYCLES: an=4'hF, cat=8'hFF.
  - Else if digit idx is suppressed: an=4'hF, cat=8'hFF.
  - Else: an=~(4'b0001<<idx), cat[6:0]=seg(snap nibble idx), cat[7]=~dp_mask[idx]. dp_mask is sampled live, not snapshotted.
- Segment encoding, full cat byte with dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Leading-zero suppression (LZ_BLANK=1), evaluated on snap:
  - Digit 3 is suppressed if snap[15:12]==0.
  - Digit 2 is suppressed if snap[15:8]==0.
  - Digit 1 is suppressed if snap[15:4]==0.
  - Digit 0 is never suppressed, so value 0 shows "0".
  - A suppressed digit still shows its dp if dp_mask bit is set: an asserted, cat=8'h7F.
- With LZ_BLANK=0, all digits are always shown.
- Reset mid-slot: outputs go to off immediately (asynchronous). After release, scanning restarts at idx=0, cnt=0 with a fresh snapshot.
- At most one an bit is ever low; a glitch-free single-hot anode is mandatory.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, LZ_BLANK=1 unless noted):
- Reset held low with value=16'h1234 -> an=F, cat=FF throughout. Release, then per 4-cycle slot: 1 cycle an=F, then 3 cycles an=E/cat=99, an=D/cat=B0, an=B/cat=A4, an=7/cat=F9, repeating with period 16.
- value=16'h00A5 -> digits 3 and 2 stay dark (an never 7 or B). Digit 1 shows cat=88, digit 0 shows cat=92.
- value=16'h0000 -> only digit 0 lights with cat=C0. Repeat with LZ_BLANK=0 -> all four digits show C0.
- value changed from 16'h1111 to 16'h2222 during the idx=1 slot -> digits 1–3 keep showing F9 for the rest of the frame. The first 2222 (cat=A4) appears on digit 0 of the next frame.
- dp_mask=4'b1000 with value=16'h0007 -> digit 3 shows cat=7F (dp only), digit 0 shows F8, digits 1 and 2 stay dark.
- Reset asserted mid-slot on idx=2 -> an=F, cat=FF within the same cycle, with no clock edge needed. After release the next lit digit is digit 0.

Source files
------------

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - time-multiplexed 4-digit common-anode 7-segment scanner
module seg7_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter bit LZ_BLANK     = 1'b1
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   output logic [3:0]  an,
   output logic [7:0]  cat
);

   localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [31:0]    BLANK_U  = 32'(BLANK_CYCLES);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   snap;
   logic          init;
   logic          slot_end;
   logic [3:0]    nib;
   logic          sup;
   logic          blanking;
   logic [3:0]    an_next;
   logic [7:0]    cat_next;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign slot_end = (cnt == CNT_LAST);
   assign blanking = (32'(cnt) < BLANK_U);

   // Slot counter and digit index: each digit owns REFRESH_DIV cycles.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Frame snapshot: taken on the first edge out of reset and at every frame wrap.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         snap <= 16'h0000;
         init <= 1'b1;
      end else begin
         init <= 1'b0;
         if (init || (slot_end && idx == 2'd3)) begin
            snap <= value;
         end
      end
   end

   // Decode the current slot into the next anode/cathode pattern.
   always_comb begin
      nib      = 4'h0;
      sup      = 1'b0;
      an_next  = 4'hF;
      cat_next = 8'hFF;
      case (idx)
         2'd0:    nib = snap[3:0];
         2'd1:    nib = snap[7:4];
         2'd2:    nib = snap[11:8];
         default: nib = snap[15:12];
      endcase
      if (LZ_BLANK) begin
         case (idx)
            2'd3:    sup = (snap[15:12] == 4'h0);
            2'd2:    sup = (snap[15:8] == 8'h00);
            2'd1:    sup = (snap[15:4] == 12'h000);
            default: sup = 1'b0;
         endcase
      end
      if (!blanking) begin
         if (!sup) begin
            an_next  = ~(4'b0001 << idx);
            cat_next = {~dp_mask[idx], seg7(nib)};
         end else if (dp_mask[idx]) begin
            // A suppressed digit keeps its decimal point visible.
            an_next  = ~(4'b0001 << idx);
            cat_next = 8'h7F;
         end
      end
   end

   // Registered outputs so the anode bus is glitch-free and single-hot.
   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         an  <= 4'hF;
         cat <= 8'hFF;
      end else begin
         an  <= an_next;
         cat <= cat_next;
      end
   end

endmodule
